// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK control sequencer.
// Owns the program counter, instruction register, load-data latch,
// register-file write gating, retire/cycle counters and trap detection.
// Memories are variable latency and use a req/ready handshake. A request
// that waits TIMEOUT cycles without ready traps the core (TIMEOUT=0 disables).
//
// Ports:
//   clk, rst                  clock (rising edge), async active-low reset
//   halt                      hold in FETCH without issuing a new request
//   imem_req/addr/ready/rdata instruction fetch handshake
//   dec_reg_write/mem_write/mem_read  decoder control (stable DECODE..WRITEBACK)
//   branch_taken/target       control transfer resolved in EXECUTE
//   dmem_req/we/ready/rdata   data memory handshake
//   program_counter, instruction_register, load_data  architectural latches
//   register_write_enable     gated register-file write strobe
//   retire                    one-cycle pulse per completed instruction
//   state                     FETCH=0 DECODE=1 EXECUTE=2 MEMORY=3 WRITEBACK=4 TRAP=5
//   trap, trap_cause          sticky fault flag and cause (1 imem, 2 align, 3 dmem)
//   cycle_count, instret_count  free-running cycle and retired-instruction counters
module multicycle_sequencer #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              TIMEOUT      = 16,
  parameter int              CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  input  logic             dec_reg_write,
  input  logic             dec_mem_write,
  input  logic             dec_mem_read,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ready,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic [XLEN-1:0]  program_counter,
  output logic [31:0]      instruction_register,
  output logic [XLEN-1:0]  load_data,
  output logic             register_write_enable,
  output logic             retire,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instret_count
);

  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              fetch_pending;
  logic              taken_q;
  logic [XLEN-1:0]   target_q;
  logic              ir_load, ld_load, br_sample, trap_set, wait_inc;
  logic [1:0]        cause_d;
  logic              timeout_hit;

  // The wait counter trips on the cycle that would be the TIMEOUT-th wait.
  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WAIT_W'(TIMEOUT - 1));

  assign state     = state_q;
  assign imem_addr = program_counter;
  assign trap      = (state_q == TRAP);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= FETCH;
    else      state_q <= state_d;
  end

  // Next-state and output decode. Once a fetch is outstanding, halt no longer
  // withdraws it. The rst gate keeps imem_req low while reset is held.
  always_comb begin
    state_d               = state_q;
    imem_req              = 1'b0;
    dmem_req              = 1'b0;
    dmem_we               = 1'b0;
    register_write_enable = 1'b0;
    retire                = 1'b0;
    ir_load               = 1'b0;
    ld_load               = 1'b0;
    br_sample             = 1'b0;
    trap_set              = 1'b0;
    cause_d               = 2'd0;
    wait_inc              = 1'b0;
    case (state_q)
      FETCH: begin
        if (rst && (!halt || fetch_pending)) begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_load = 1'b1;
            state_d = DECODE;
          end else if (timeout_hit) begin
            trap_set = 1'b1;
            cause_d  = 2'd1;
            state_d  = TRAP;
          end else begin
            wait_inc = (TIMEOUT != 0);
          end
        end
      end
      DECODE: state_d = EXECUTE;
      EXECUTE: begin
        br_sample = 1'b1;
        if (branch_taken && (branch_target[1:0] != 2'b00)) begin
          trap_set = 1'b1;
          cause_d  = 2'd2;
          state_d  = TRAP;
        end else if (dec_mem_read || dec_mem_write) begin
          state_d = MEMORY;
        end else begin
          state_d = WRITEBACK;
        end
      end
      MEMORY: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_write;
        if (dmem_ready) begin
          ld_load = dec_mem_read && !dec_mem_write;
          state_d = WRITEBACK;
        end else if (timeout_hit) begin
          trap_set = 1'b1;
          cause_d  = 2'd3;
          state_d  = TRAP;
        end else begin
          wait_inc = (TIMEOUT != 0);
        end
      end
      WRITEBACK: begin
        register_write_enable = dec_reg_write;
        retire                = 1'b1;
        state_d               = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  // Datapath latches, counters and wait tracking. The wait counter and the
  // outstanding-fetch flag clear whenever the state changes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      program_counter      <= RESET_VECTOR;
      instruction_register <= '0;
      load_data            <= '0;
      taken_q              <= 1'b0;
      target_q             <= '0;
      trap_cause           <= 2'd0;
      cycle_count          <= '0;
      instret_count        <= '0;
      wait_q               <= '0;
      fetch_pending        <= 1'b0;
    end else begin
      cycle_count <= cycle_count + CNT_W'(1);
      if (ir_load) instruction_register <= imem_rdata;
      if (ld_load) load_data <= dmem_rdata;
      if (br_sample) begin
        taken_q  <= branch_taken;
        target_q <= branch_target;
      end
      if (retire) begin
        instret_count   <= instret_count + CNT_W'(1);
        program_counter <= taken_q ? target_q : program_counter + XLEN'(4);
      end
      if (trap_set) trap_cause <= cause_d;
      if (state_d != state_q) begin
        wait_q        <= '0;
        fetch_pending <= 1'b0;
      end else begin
        if (wait_inc) wait_q <= wait_q + WAIT_W'(1);
        if (state_q == FETCH && imem_req) fetch_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer
// Self-checking bench for multicycle_sequencer (default parameters). The bench
// acts as instruction/data memory and decoder, and predicts PC, retire timing,
// load data and counters from an instruction-level model.
module tb_multicycle_sequencer;

  localparam int TMO = 16;
  localparam logic [2:0] S_FETCH = 3'd0;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_TRAP  = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        halt = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dec_reg_write = 1'b0, dec_mem_write = 1'b0, dec_mem_read = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        dmem_req, dmem_we;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic [31:0] program_counter, load_data;
  logic [31:0] instruction_register;
  logic        register_write_enable, retire, trap;
  logic [2:0]  state;
  logic [1:0]  trap_cause;
  logic [31:0] cycle_count, instret_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instret, m_load, m_cycles;

  multicycle_sequencer dut (
    .clk(clk), .rst(rst), .halt(halt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata),
    .dec_reg_write(dec_reg_write), .dec_mem_write(dec_mem_write),
    .dec_mem_read(dec_mem_read),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .dmem_rdata(dmem_rdata),
    .program_counter(program_counter), .instruction_register(instruction_register),
    .load_data(load_data), .register_write_enable(register_write_enable),
    .retire(retire), .state(state), .trap(trap), .trap_cause(trap_cause),
    .cycle_count(cycle_count), .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  // Cycles elapsed since reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_cycles <= '0;
    else      m_cycles <= m_cycles + 32'd1;
  end

  // Hold reset, check reset values, release just after a rising edge.
  task automatic test_reset();
    rst = 1'b0; halt = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
    dec_reg_write = 1'b0; dec_mem_write = 1'b0; dec_mem_read = 1'b0;
    branch_taken = 1'b0; branch_target = '0;
    repeat (2) @(negedge clk);
    checks++; if (state !== S_FETCH) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
    checks++; if (program_counter !== 32'd0) begin errors++; $display("[TB] FAIL reset_pc: got %h want 0", program_counter); end
    checks++; if (instruction_register !== 32'd0 || load_data !== 32'd0) begin errors++; $display("[TB] FAIL reset_latches: ir %h ld %h want 0", instruction_register, load_data); end
    checks++; if ({imem_req, dmem_req, dmem_we, register_write_enable, retire} !== 5'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b want 00000", {imem_req, dmem_req, dmem_we, register_write_enable, retire}); end
    checks++; if (trap !== 1'b0 || trap_cause !== 2'd0) begin errors++; $display("[TB] FAIL reset_trap: trap %b cause %0d want 0/0", trap, trap_cause); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_counters: cyc %0d ret %0d want 0/0", cycle_count, instret_count); end
    @(posedge clk); #1 rst = 1'b1;
    m_pc = 32'd0; m_instret = 32'd0; m_load = 32'd0;
  endtask

  // Runs one instruction as memory/decoder environment. exp_cause=0 expects a
  // retire; 2 or 3 expects a trap with that cause.
  task automatic run_instr(input bit rd, input bit wr, input bit rw, input bit tk,
                           input logic [31:0] tgt, input int iwait, input int dwait,
                           input int exp_cause, input string name);
    logic [31:0] instr, rdata;
    int cyc, iw, dw, rwe_cnt, exp_cyc;
    bit done, saw_retire, is_mem, is_load;
    instr = $urandom; rdata = $urandom;
    cyc = 0; iw = 0; dw = 0; rwe_cnt = 0; done = 0; saw_retire = 0;
    dec_mem_read = rd; dec_mem_write = wr; dec_reg_write = rw;
    branch_taken = tk; branch_target = tgt;
    is_mem = rd | wr; is_load = rd & ~wr;
    if (exp_cause == 2)      exp_cyc = 4 + iwait;
    else if (exp_cause == 3) exp_cyc = 4 + iwait + TMO;
    else                     exp_cyc = 4 + iwait + (is_mem ? 1 + dwait : 0);
    while (!done && cyc < 300) begin
      @(negedge clk); cyc++;
      imem_ready = 1'b0; dmem_ready = 1'b0;
      imem_rdata = $urandom; dmem_rdata = $urandom;
      checks++; if (program_counter !== m_pc) begin errors++; $display("[TB] FAIL %s pc: got %h want %h", name, program_counter, m_pc); end
      checks++; if (cycle_count !== m_cycles || instret_count !== m_instret) begin errors++; $display("[TB] FAIL %s counters: cyc %0d ret %0d want %0d %0d", name, cycle_count, instret_count, m_cycles, m_instret); end
      if (imem_req) begin
        checks++; if (imem_addr !== m_pc) begin errors++; $display("[TB] FAIL %s imem_addr: got %h want %h", name, imem_addr, m_pc); end
        if (iw == iwait) begin imem_ready = 1'b1; imem_rdata = instr; end
        else iw++;
      end
      if (dmem_req) begin
        checks++; if (dmem_we !== wr) begin errors++; $display("[TB] FAIL %s dmem_we: got %b want %b", name, dmem_we, wr); end
        if (dw == dwait) begin dmem_ready = 1'b1; dmem_rdata = rdata; end
        else dw++;
      end
      if (register_write_enable) rwe_cnt++;
      if (retire) begin saw_retire = 1; done = 1; end
      if (state == S_TRAP) done = 1;
    end
    checks++; if (!done) begin errors++; $display("[TB] FAIL %s budget: got no end after %0d cycles want end", name, cyc); end
    checks++; if (cyc != exp_cyc) begin errors++; $display("[TB] FAIL %s latency: got %0d want %0d", name, cyc, exp_cyc); end
    if (exp_cause != 0) begin
      checks++; if (state !== S_TRAP || trap !== 1'b1) begin errors++; $display("[TB] FAIL %s trap_state: got %0d/%b want 5/1", name, state, trap); end
      checks++; if (trap_cause !== exp_cause[1:0]) begin errors++; $display("[TB] FAIL %s trap_cause: got %0d want %0d", name, trap_cause, exp_cause); end
      checks++; if (saw_retire || rwe_cnt != 0) begin errors++; $display("[TB] FAIL %s no_retire: got retire %b rwe %0d want 0", name, saw_retire, rwe_cnt); end
    end else begin
      checks++; if (rwe_cnt != int'(rw)) begin errors++; $display("[TB] FAIL %s rwe_pulses: got %0d want %0d", name, rwe_cnt, rw); end
      checks++; if (instruction_register !== instr) begin errors++; $display("[TB] FAIL %s ir: got %h want %h", name, instruction_register, instr); end
      if (is_load) m_load = rdata;
      checks++; if (load_data !== m_load) begin errors++; $display("[TB] FAIL %s load_data: got %h want %h", name, load_data, m_load); end
      m_instret = m_instret + 32'd1;
      m_pc = tk ? tgt : m_pc + 32'd4;
    end
  endtask

  task automatic test_alu();
    for (int i = 0; i < 3; i++) run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "alu");
    checks++; if (m_pc !== 32'd12) begin errors++; $display("[TB] FAIL alu_seq_pc: got %h want c", m_pc); end
  endtask

  task automatic test_load_wait();
    run_instr(1, 0, 1, 0, 32'd0, 0, 2, 0, "load_wait2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      bit tk;
      logic [31:0] tgt;
      tk = ($urandom_range(0, 3) == 0);
      tgt = $urandom & 32'hFFFF_FFFC;
      run_instr($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1), tk,
                tgt, $urandom_range(0, 3), $urandom_range(0, 3), 0, "random");
    end
  endtask

  task automatic test_branch();
    run_instr(0, 0, 0, 1, 32'h20, 0, 0, 0, "br_to_20");
    run_instr(0, 0, 0, 1, 32'h100, 1, 0, 0, "br_20_to_100");
    run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "after_br_100");
    run_instr(0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, "br_to_top");
    run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "pc_wrap");
    checks++; if (m_pc !== 32'd0) begin errors++; $display("[TB] FAIL pc_wrap_model: got %h want 0", m_pc); end
  endtask

  task automatic test_halt();
    run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "pre_halt");
    halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0 || state !== S_FETCH) begin errors++; $display("[TB] FAIL halt_hold: req %b state %0d want 0/0", imem_req, state); end
      checks++; if (program_counter !== m_pc) begin errors++; $display("[TB] FAIL halt_pc: got %h want %h", program_counter, m_pc); end
    end
    halt = 1'b0;
    run_instr(0, 0, 1, 0, 32'd0, 2, 0, 0, "post_halt");
  endtask

  task automatic test_misaligned();
    run_instr(0, 0, 0, 1, 32'h20, 0, 0, 0, "br_to_20b");
    run_instr(0, 0, 1, 1, 32'h102, 0, 0, 2, "misaligned");
    checks++; if (program_counter !== 32'h20) begin errors++; $display("[TB] FAIL misaligned_pc: got %h want 20", program_counter); end
  endtask

  task automatic test_imem_timeout();
    int waits, cyc;
    waits = 0; cyc = 0;
    imem_ready = 1'b0;
    while (cyc < 100) begin
      @(negedge clk); cyc++;
      if (state == S_TRAP) break;
      if (imem_req) waits++;
    end
    checks++; if (waits != TMO) begin errors++; $display("[TB] FAIL imem_timeout_waits: got %0d want %0d", waits, TMO); end
    checks++; if (trap !== 1'b1 || trap_cause !== 2'd1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL imem_timeout_trap: trap %b cause %0d req %b want 1/1/0", trap, trap_cause, imem_req); end
    repeat (3) @(negedge clk);
    checks++; if (cycle_count !== 32'd19 || state !== S_TRAP) begin errors++; $display("[TB] FAIL trap_cycle_count: got %0d state %0d want 19/5", cycle_count, state); end
  endtask

  task automatic test_dmem_timeout();
    run_instr(0, 1, 0, 0, 32'd0, 0, 1000, 3, "store_timeout");
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0) begin errors++; $display("[TB] FAIL store_timeout_strobes: req %b we %b want 0/0", dmem_req, dmem_we); end
  endtask

  task automatic test_reset_mid_store();
    int cyc;
    cyc = 0;
    run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "pre_store");
    dec_mem_write = 1'b1; dec_mem_read = 1'b0; dec_reg_write = 1'b0; branch_taken = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0;
    while (state != S_MEM && cyc < 20) begin @(negedge clk); cyc++; end
    imem_ready = 1'b0;
    @(negedge clk);
    checks++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("[TB] FAIL pre_abort_store: req %b we %b want 1/1", dmem_req, dmem_we); end
    #2 rst = 1'b0;
    #1;
    checks++; if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || retire !== 1'b0) begin errors++; $display("[TB] FAIL abort_strobes: req %b we %b ret %b want 0", dmem_req, dmem_we, retire); end
    checks++; if (program_counter !== 32'd0 || state !== S_FETCH) begin errors++; $display("[TB] FAIL abort_pc: pc %h state %0d want 0/0", program_counter, state); end
    checks++; if (cycle_count !== 32'd0 || instret_count !== 32'd0) begin errors++; $display("[TB] FAIL abort_counters: cyc %0d ret %0d want 0/0", cycle_count, instret_count); end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_wait();
    test_branch();
    test_random();
    test_halt();
    test_misaligned();
    test_reset();
    test_imem_timeout();
    test_reset();
    test_dmem_timeout();
    test_reset();
    test_reset_mid_store();
    test_reset();
    run_instr(0, 0, 1, 0, 32'd0, 0, 0, 0, "post_abort");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised control sequencer for the next-generation WaveRV core. It replaces the implicit one-instruction-per-clock flow with a multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK state machine.
- It supports variable-latency memories through req/ready handshakes.
- It owns the program counter, instruction register, write-enable gating, retire/cycle counters and trap detection.
- It sits between the instruction/data memories and the existing decoder, register file and ALU.

Parameters:
- XLEN, 32, datapath and address width (>= 8).
- RESET_VECTOR, 0, PC value after reset.
- TIMEOUT, 16, max cycles a memory request may wait for ready; 0 disables the timeout.
- CNT_W, 32, width of cycle_count and instret_count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-low.
- halt  in  1  when high, sequencer holds in FETCH without issuing a request.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  XLEN  fetch address (= program_counter).
- imem_ready  in  1  fetch data valid this cycle.
- imem_rdata  in  32  fetched instruction.
- dec_reg_write  in  1  decoder: instruction writes rd.
- dec_mem_write  in  1  decoder: store.
- dec_mem_read  in  1  decoder: load.
- branch_taken  in  1  control transfer resolved taken (valid in EXECUTE).
- branch_target  in  XLEN  target address (valid in EXECUTE).
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write strobe (only with dmem_req).
- dmem_ready  in  1  data access complete this cycle.
- dmem_rdata  in  XLEN  load data.
- program_counter  out  XLEN  current PC.
- instruction_register  out  32  latched instruction.
- load_data  out  XLEN  latched load result for writeback mux.
- register_write_enable  out  1  gated register-file write strobe.
- retire  out  1  one-cycle pulse per completed instruction.
- state  out  3  FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4, TRAP=5.
- trap  out  1  sticky fault flag.
- trap_cause  out  2  1=imem timeout, 2=misaligned target, 3=dmem timeout.
- cycle_count  out  CNT_W  cycles since reset.
- instret_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (rst=0, async): state=FETCH, program_counter=RESET_VECTOR, instruction_register=0, load_data=0, all req/we/strobe outputs 0, trap=0, trap_cause=0, counters=0, wait counter=0. Reset asserted mid-access aborts the access immediately; no write or retire occurs.
- FETCH:
  - If halt=1: imem_req=0, stay.
  - Otherwise imem_req=1 and imem_addr=program_counter.
  - If imem_ready=1 in the same cycle: instruction_register<=imem_rdata, go to DECODE (single-cycle fetch is legal).
  - halt is ignored once a request has been issued and is not yet ready; the request is held until ready or timeout.
- DECODE: one cycle; no outputs asserted; go to EXECUTE.
- EXECUTE: one cycle; sample branch_taken/branch_target into internal regs.
  - If branch_taken and branch_target[1:0]!=0: go to TRAP with cause 2; PC is unchanged.
  - Else if dec_mem_read or dec_mem_write: go to MEMORY.
  - Else: go to WRITEBACK.
  - If both dec_mem_read and dec_mem_write are set, treat the instruction as a store.
- MEMORY:
  - dmem_req=1 and dmem_we=dec_mem_write.
  - On dmem_ready=1: if the access is a load, load_data<=dmem_rdata; go to WRITEBACK.
- WRITEBACK: one cycle.
  - register_write_enable=dec_reg_write.
  - retire=1.
  - instret_count+1.
  - program_counter <= taken ? sampled target : program_counter+4 (mod 2^XLEN; wraps at top).
  - Go to FETCH.
- Timeout:
  - Applies in FETCH and MEMORY while req=1 and ready=0; a wait counter increments each such cycle.
  - When the counter reaches TIMEOUT and ready is still 0: go to TRAP with cause 1 or 3.
  - The wait counter clears on every state change.
  - When TIMEOUT=0 there is no timeout.
- TRAP: all req/we/strobe outputs 0; trap=1; cause held; leaves only via reset.
- Counters:
  - cycle_count increments every cycle out of reset, including TRAP and halt; wraps modulo 2^CNT_W.
  - instret_count wraps likewise.
- Latency: ALU instruction = 4 cycles with zero-wait memory; load/store = 5 cycles plus memory wait cycles.
- Decoder inputs are assumed stable from DECODE through WRITEBACK (IR-driven); the sequencer does not re-latch them.

Test Plan:
- Reset release, zero-wait imem, 3 ALU instructions: retire pulses on cycles 4, 8, 12; program_counter 0→4→8→12; instret_count=3.
- Load with dmem_ready delayed 2 cycles, dmem_rdata=0xDEADBEEF: MEMORY lasts 3 cycles; load_data=0xDEADBEEF; register_write_enable high exactly 1 cycle; total 7 cycles.
- Taken branch to 0x100 from PC 0x20: next imem_addr=0x100. Taken branch to 0x102: state=TRAP, trap_cause=2, program_counter stays 0x20, no retire.
- TIMEOUT=16, imem_ready held 0: trap asserts after exactly 16 waiting cycles with cause 1; cycle_count keeps counting. Same test on a store gives cause 3 with dmem_we held 1 until TRAP.
- halt=1 at FETCH for 5 cycles: imem_req=0 throughout; fetch resumes with the unchanged PC when halt drops.
- rst pulled low during MEMORY of a store: dmem_req/dmem_we drop asynchronously; PC=RESET_VECTOR; no retire; counters=0.
